// File: rtl/ex_mem_pipe_pkg.sv
// ex_mem_pkg: default widths, stage state encoding and payload layout for the EX/MEM register.
package ex_mem_pkg;
    localparam int DEF_WB_W   = 2;
    localparam int DEF_M_W    = 3;
    localparam int DEF_RD_W   = 5;
    localparam int DEF_DATA_W = 32;
    localparam int DEF_CNT_W  = 16;
    typedef enum logic [1:0] {EMPTY, FULL, SKID} state_t;
    typedef struct packed {
        logic [DEF_WB_W-1:0]   wb;
        logic [DEF_M_W-1:0]    m;
        logic [DEF_RD_W-1:0]   rd;
        logic [DEF_DATA_W-1:0] alu;
        logic [DEF_DATA_W-1:0] wdata;
    } payload_t;
endpackage

// File: rtl/ex_mem_pipe_slot.sv
// pipe_slot: one payload register with valid bit; clear drops the entry and zeroes the
// control field held in the top C bits so a squashed entry can never act.
module pipe_slot #(
    parameter int W = 8,
    parameter int C = 1
) (
    input  logic         clock,
    input  logic         reset,
    input  logic         load,
    input  logic         unload,
    input  logic         clear,
    input  logic [W-1:0] d,
    output logic         valid,
    output logic [W-1:0] q
);
    always_ff @(posedge clock) begin
        if (reset) begin
            valid <= 1'b0;
            q     <= '0;
        end else if (clear) begin
            valid      <= 1'b0;
            q[W-1 -: C] <= '0;
        end else if (load) begin
            valid <= 1'b1;
            q     <= d;
        end else if (unload) begin
            valid <= 1'b0;
        end
    end
endmodule

// File: rtl/ex_mem_pipe.sv
// ex_mem_pipe: EX/MEM interstage register with valid/ready, flush and saturating stall counter.
// Define EX_MEM_PIPE_SKID_EN to add a skid slot and register in_ready.
module ex_mem_pipe
    import ex_mem_pkg::*;
#(
    parameter int WB_W   = DEF_WB_W,
    parameter int M_W    = DEF_M_W,
    parameter int RD_W   = DEF_RD_W,
    parameter int DATA_W = DEF_DATA_W,
    parameter int CNT_W  = DEF_CNT_W
) (
    input  logic              clock,
    input  logic              reset,
    input  logic              flush,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [WB_W-1:0]   WB,
    input  logic [M_W-1:0]    M,
    input  logic [RD_W-1:0]   rd,
    input  logic [DATA_W-1:0] ALUout,
    input  logic [DATA_W-1:0] writeDataIn,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [WB_W-1:0]   WBRegister,
    output logic [M_W-1:0]    MRegister,
    output logic [RD_W-1:0]   rdRegister,
    output logic [DATA_W-1:0] ALURegister,
    output logic [DATA_W-1:0] writeDataOut,
    output logic [CNT_W-1:0]  stallCount
);
    localparam int C = WB_W + M_W;
    localparam int W = C + RD_W + 2 * DATA_W;
    logic [W-1:0]      in_bus, main_d, main_q;
    logic              main_v, main_ld, acc, con;
    logic [WB_W-1:0]   wb_q;
    logic [M_W-1:0]    m_q;
    assign in_bus = {WB, M, rd, ALUout, writeDataIn};
    assign acc = in_valid && in_ready;
    assign con = out_valid && out_ready;
`ifdef EX_MEM_PIPE_SKID_EN
    logic [W-1:0] skid_q;
    logic         skid_v, rdy_q;
    state_t       state, nxt;
    assign in_ready = rdy_q && !reset;
    assign main_d = skid_v ? skid_q : in_bus;
    assign main_ld = (acc || skid_v) && (con || !main_v);
    pipe_slot #(.W(W), .C(C)) skid_slot (
        .clock(clock), .reset(reset), .load(acc && main_v && !con), .unload(con),
        .clear(flush), .d(in_bus), .valid(skid_v), .q(skid_q)
    );
    always_comb begin
        nxt = flush ? EMPTY :
              state == EMPTY ? (acc ? FULL : EMPTY) :
              state == FULL  ? (acc && !con ? SKID : (!acc && con ? EMPTY : FULL)) :
              (con ? FULL : SKID);
    end
    // in_ready comes straight from a flop, cutting the path from out_ready
    always_ff @(posedge clock) begin
        if (reset) begin
            state <= EMPTY;
            rdy_q <= 1'b1;
        end else begin
            state <= nxt;
            rdy_q <= nxt != SKID;
        end
    end
`else
    assign in_ready = !reset && (!main_v || out_ready);
    assign main_d = in_bus;
    assign main_ld = acc;
`endif
    pipe_slot #(.W(W), .C(C)) main_slot (
        .clock(clock), .reset(reset), .load(main_ld), .unload(con),
        .clear(flush), .d(main_d), .valid(main_v), .q(main_q)
    );
    assign out_valid = main_v;
    assign {wb_q, m_q, rdRegister, ALURegister, writeDataOut} = main_q;
    assign WBRegister = main_v ? wb_q : '0;
    assign MRegister = main_v ? m_q : '0;
    always_ff @(posedge clock) begin
        if (reset)
            stallCount <= '0;
        else if (out_valid && !out_ready && !(&stallCount))
            stallCount <= stallCount + 1'b1;
    end
endmodule

// File: tb/tb_ex_mem_pipe.sv
// tb_ex_mem_pipe: random and directed traffic against a queue-based model of the stage.
module tb_ex_mem_pipe;
    logic        clock = 1'b0, reset, flush, in_valid, out_ready, in_ready, out_valid;
    logic [1:0]  WB, WBRegister;
    logic [2:0]  M, MRegister;
    logic [4:0]  rd, rdRegister;
    logic [31:0] ALUout, writeDataIn, ALURegister, writeDataOut;
    logic [3:0]  stallCount;
    int total = 0, bad = 0;
    typedef struct {
        logic [1:0]  wb;
        logic [2:0]  m;
        logic [4:0]  rd;
        logic [31:0] alu;
        logic [31:0] wd;
    } beat_t;
    beat_t q[$];
    beat_t last;
    int    cnt;
`ifdef EX_MEM_PIPE_SKID_EN
    localparam int CAP = 2;
`else
    localparam int CAP = 1;
`endif
    always #5 clock = ~clock;
    ex_mem_pipe #(.CNT_W(4)) dut (
        .clock(clock), .reset(reset), .flush(flush), .in_valid(in_valid), .in_ready(in_ready),
        .WB(WB), .M(M), .rd(rd), .ALUout(ALUout), .writeDataIn(writeDataIn),
        .out_valid(out_valid), .out_ready(out_ready), .WBRegister(WBRegister),
        .MRegister(MRegister), .rdRegister(rdRegister), .ALURegister(ALURegister),
        .writeDataOut(writeDataOut), .stallCount(stallCount)
    );
    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s got=%0h exp=%0h at %0t", tag, got, exp, $time);
        end
    endtask
    function automatic logic model_ready();
        if (reset) return 1'b0;
        if (CAP == 2) return q.size() < 2;
        return q.size() == 0 || out_ready;
    endfunction
    function automatic beat_t mk(input logic [31:0] alu, input logic [4:0] d, input logic [1:0] wb,
                                 input logic [2:0] m);
        beat_t b;
        b.alu = alu; b.rd = d; b.wb = wb; b.m = m; b.wd = $urandom;
        return b;
    endfunction
    task automatic cyc(input bit r, input bit f, input bit v, input bit o, input beat_t b);
        bit rdy, acc, con, full;
        reset = r; flush = f; in_valid = v; out_ready = o;
        WB = b.wb; M = b.m; rd = b.rd; ALUout = b.alu; writeDataIn = b.wd;
        #1;
        full = q.size() > 0;
        rdy = model_ready();
        chk("in_ready", in_ready, rdy);
        chk("out_valid", out_valid, full);
        chk("WBRegister", WBRegister, full ? q[0].wb : 2'b0);
        chk("MRegister", MRegister, full ? q[0].m : 3'b0);
        chk("rdRegister", rdRegister, last.rd);
        chk("ALURegister", ALURegister, last.alu);
        chk("writeDataOut", writeDataOut, last.wd);
        chk("stallCount", stallCount, cnt);
        acc = v && rdy;
        con = full && o;
        @(posedge clock);
        if (r) begin
            q.delete();
            last = '{default: '0};
            cnt = 0;
        end else begin
            if (full && !o && cnt < 15) cnt++;
            if (f) q.delete();
            else begin
                if (con) void'(q.pop_front());
                if (acc) q.push_back(b);
            end
            if (q.size() > 0) last = q[0];
        end
        @(negedge clock);
    endtask
    beat_t idle;
    initial begin
        idle = '{default: '0};
        last = '{default: '0};
        cnt = 0;
        reset = 1'b1; flush = 1'b0; in_valid = 1'b0; out_ready = 1'b0;
        WB = '0; M = '0; rd = '0; ALUout = '0; writeDataIn = '0;
        @(posedge clock);
        @(negedge clock);
        cyc(1, 0, 0, 0, idle);
        for (int i = 0; i < 4; i++) cyc(0, 0, 1, 1, mk(32'h10 * (i + 1), 5'(i + 1), 2'(i), 3'(i)));
        repeat (2) cyc(0, 0, 0, 1, idle);
        chk("stream_stall0", stallCount, 4'd0);
        cyc(0, 0, 1, 0, mk(32'hAA, 5'd7, 2'b11, 3'b101));
        cyc(0, 0, 1, 0, mk(32'hBB, 5'd8, 2'b01, 3'b011));
        repeat (4) cyc(0, 0, 0, 0, idle);
        chk("stall5", stallCount, 4'd5);
        chk("held_alu", ALURegister, 32'hAA);
        repeat (3) cyc(0, 0, 0, 1, idle);
        cyc(0, 0, 1, 0, mk(32'h55, 5'd9, 2'b11, 3'b010));
        cyc(0, 1, 1, 0, mk(32'hCC, 5'd10, 2'b10, 3'b110));
        chk("flush_valid", out_valid, 1'b0);
        chk("flush_wb", WBRegister, 2'b0);
        repeat (2) cyc(0, 0, 0, 1, idle);
        cyc(0, 0, 1, 0, mk(32'hDD, 5'd11, 2'b11, 3'b111));
        cyc(0, 0, 1, 0, mk(32'hEE, 5'd12, 2'b10, 3'b001));
        repeat (18) cyc(0, 0, 0, 0, idle);
        chk("sat15", stallCount, 4'd15);
        cyc(1, 0, 1, 0, mk(32'hFF, 5'd13, 2'b11, 3'b111));
        chk("rst_valid", out_valid, 1'b0);
        chk("rst_alu", ALURegister, 32'h0);
        chk("rst_cnt", stallCount, 4'd0);
        cyc(0, 0, 0, 1, idle);
        for (int i = 0; i < 500; i++)
            cyc($urandom % 40 == 0, $urandom % 12 == 0, $urandom % 3 != 0, $urandom % 4 != 0,
                mk($urandom, 5'($urandom), 2'($urandom), 3'($urandom)));
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
